// File: rtl/gen_vdu_clock.sv
// ---------------------------------------------------------------------------
// gen_vdu_clock
//   Synchronous integer divider that derives the VDU (VGA pixel) clock from
//   the system clock. The divided clock is a registered, glitch-free square
//   wave. A one-cycle clock-enable strobe marks each of its rising edges, so
//   downstream sync/pixel logic can stay in the sysclk domain.
//
//   Parameters
//     DIV    division ratio, 2..65536. The output period is DIV sysclk cycles.
//            The low phase is floor(DIV/2) cycles and the high phase gets the
//            remainder, so an odd DIV has a high phase one cycle longer.
//     CNT_W  phase counter width. Derived from DIV; do not override.
//
//   Ports
//     sysclk  in   system clock; everything is on its rising edge
//     rst     in   synchronous, active-high reset
//     hold    in   (only with VDUCLK_HOLD_EN) freeze the phase, no strobes
//     vduclk  out  divided clock, straight from a flop
//     vdu_ce  out  one-sysclk pulse in the first cycle vduclk reads 1
//
//   Optional feature macro: VDUCLK_HOLD_EN
//     When defined, the hold input is added. While hold=1 (and rst=0) the
//     counter and vduclk keep their values and vdu_ce is 0. Counting resumes
//     from the held phase. rst takes priority over hold.
// ---------------------------------------------------------------------------
module gen_vdu_clock #(
    parameter int DIV   = 2,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic sysclk,
    input  logic rst,
`ifdef VDUCLK_HOLD_EN
    input  logic hold,
`endif
    output logic vduclk,
    output logic vdu_ce
);

    // Reject illegal configurations at elaboration time.
    generate
        if (DIV < 2 || DIV > 65536) begin : g_bad_div
            $error("gen_vdu_clock: DIV=%0d outside legal range 2..65536", DIV);
        end
        if (CNT_W != $clog2(DIV)) begin : g_bad_cnt_w
            $error("gen_vdu_clock: CNT_W=%0d must equal $clog2(DIV)=%0d", CNT_W, $clog2(DIV));
        end
    endgenerate

    localparam int               LOW_CYC = DIV / 2;
    localparam logic [CNT_W-1:0] LOW_C   = LOW_CYC[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             run;

`ifdef VDUCLK_HOLD_EN
    assign run = ~hold;
`else
    assign run = 1'b1;
`endif

    // Counter position 0 is the first low-phase cycle; positions LOW_C and up
    // are the high phase. The outputs are decoded from the *next* count so
    // they land in flops on the same edge the counter advances.
    always_comb begin
        cnt_nxt = (cnt == LAST_C) ? '0 : cnt + CNT_W'(1);
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            cnt    <= '0;
            vduclk <= 1'b0;
            vdu_ce <= 1'b0;
        end else if (!run) begin
            // Phase frozen: cnt and vduclk hold, no strobe.
            vdu_ce <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            vduclk <= (cnt_nxt >= LOW_C);
            vdu_ce <= (cnt_nxt == LOW_C);
        end
    end

endmodule

// File: tb/tb_gen_vdu_clock.sv
// ---------------------------------------------------------------------------
// tb_gen_vdu_clock
//   Three dividers (DIV = 2, 4, 5) share one 40 ns sysclk, each with its own
//   reset (and hold when VDUCLK_HOLD_EN is defined). A reference model tracks
//   the number of counted cycles since reset for each instance and derives
//   the expected outputs from the position inside the period.
// ---------------------------------------------------------------------------
module tb_gen_vdu_clock;

    logic sysclk = 1'b0;
    always #20 sysclk = ~sysclk;

    logic [2:0] rst_v;
    logic [2:0] hold_v;
    logic [2:0] vclk;
    logic [2:0] ce;

    localparam int DIVS [3] = '{2, 4, 5};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    gen_vdu_clock #(.DIV(2)) u_d2 (
        .sysclk (sysclk),
        .rst    (rst_v[0]),
`ifdef VDUCLK_HOLD_EN
        .hold   (hold_v[0]),
`endif
        .vduclk (vclk[0]),
        .vdu_ce (ce[0])
    );

    gen_vdu_clock #(.DIV(4)) u_d4 (
        .sysclk (sysclk),
        .rst    (rst_v[1]),
`ifdef VDUCLK_HOLD_EN
        .hold   (hold_v[1]),
`endif
        .vduclk (vclk[1]),
        .vdu_ce (ce[1])
    );

    gen_vdu_clock #(.DIV(5)) u_d5 (
        .sysclk (sysclk),
        .rst    (rst_v[2]),
`ifdef VDUCLK_HOLD_EN
        .hold   (hold_v[2]),
`endif
        .vduclk (vclk[2]),
        .vdu_ce (ce[2])
    );

    // ---------------- reference model ----------------
    // t[i] = counted cycles since the last reset edge (hold cycles excluded).
    // Expected: position p = t mod DIV; vduclk = (p >= DIV/2);
    // vdu_ce = (p == DIV/2) in a counted (non-held) cycle.
    int         t [3] = '{0, 0, 0};
    logic [2:0] rst_q  = '0;
    logic [2:0] hold_q = '0;
    logic [2:0] prev_v = '0;
    bit         started = 1'b0;

    always @(posedge sysclk) begin
        for (int i = 0; i < 3; i++) begin
            rst_q[i] = rst_v[i];
`ifdef VDUCLK_HOLD_EN
            hold_q[i] = hold_v[i] & ~rst_v[i];
`else
            hold_q[i] = 1'b0;
`endif
            if (rst_v[i])        t[i] = 0;
            else if (!hold_q[i]) t[i] = t[i] + 1;
        end
        started = 1'b1;
    end

    function automatic int phase(input int i);
        return t[i] % DIVS[i];
    endfunction

    always @(negedge sysclk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_vduclk_div%0d", DIVS[i]), vclk[i],
                    (phase(i) >= DIVS[i] / 2) ? 1 : 0);
                chk($sformatf("model_ce_div%0d", DIVS[i]), ce[i],
                    (!hold_q[i] && phase(i) == DIVS[i] / 2) ? 1 : 0);
                if (ce[i] === 1'b1)
                    chk($sformatf("inv_ce_on_rise_div%0d", DIVS[i]), {vclk[i], prev_v[i]}, 2'b10);
                if (rst_q[i])
                    chk($sformatf("inv_rst_quiet_div%0d", DIVS[i]), {vclk[i], ce[i]}, 2'b00);
                prev_v[i] = vclk[i];
            end
        end
    end

    // ---------------- directed table for DIV=4 ----------------
    typedef struct {
        logic rst;
        logic v;
        logic c;
    } vec_t;

    vec_t tab [13];

    task automatic step();
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    int hi4, ce4, hi5, ce5, last5, gmin, gmax;

    initial begin
        // rst, expected vduclk, expected vdu_ce after the edge
        tab = '{
            '{1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1},
            '{1'b1, 1'b0, 1'b0},   // reset while high
            '{1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1},   // first rise 2 edges after release
            '{1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0}
        };

        rst_v  = 3'b111;
        hold_v = 3'b000;

        // DIV=2 timing: edges at 20, 60, 100, 140, 180 ns; rst low at 90 ns.
        #90 rst_v[0] = 1'b0;
        #9  chk("d2_pre_vduclk", vclk[0], 0);
            chk("d2_pre_ce",     ce[0],   0);
        #2  chk("d2_rise100_vduclk", vclk[0], 1);
            chk("d2_rise100_ce",     ce[0],   1);
        #40 chk("d2_fall140_vduclk", vclk[0], 0);
            chk("d2_fall140_ce",     ce[0],   0);
        #40 chk("d2_rise180_vduclk", vclk[0], 1);
            chk("d2_rise180_ce",     ce[0],   1);

        @(negedge sysclk);
        for (int i = 0; i < 13; i++) begin
            rst_v[1] = tab[i].rst;
            step();
            chk($sformatf("tab%0d_vduclk", i), vclk[1], tab[i].v);
            chk($sformatf("tab%0d_ce", i),     ce[1],   tab[i].c);
        end

`ifdef VDUCLK_HOLD_EN
        // Hold for 3 cycles in the first high cycle of DIV=4.
        rst_v[1] = 1'b1; step();
        rst_v[1] = 1'b0; step();
        step();
        chk("hold_pre_vduclk", vclk[1], 1);
        chk("hold_pre_ce",     ce[1],   1);
        hold_v[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("hold%0d_vduclk", k), vclk[1], 1);
            chk($sformatf("hold%0d_ce", k),     ce[1],   0);
        end
        hold_v[1] = 1'b0;
        step(); chk("hold_rel0_vduclk", vclk[1], 1); chk("hold_rel0_ce", ce[1], 0);
        step(); chk("hold_rel1_vduclk", vclk[1], 0);
        step(); chk("hold_rel2_vduclk", vclk[1], 0);
        step(); chk("hold_rel3_vduclk", vclk[1], 1); chk("hold_rel3_ce", ce[1], 1);
`endif

        // Cadence: DIV=4 over 100 periods, DIV=5 over 1000 cycles.
        rst_v[2:1] = 2'b11; step();
        rst_v[2:1] = 2'b00;
        hi4 = 0; ce4 = 0; hi5 = 0; ce5 = 0;
        last5 = -1; gmin = 1000000; gmax = 0;
        for (int k = 1; k <= 1000; k++) begin
            step();
            if (k <= 400) begin
                hi4 += int'(vclk[1] === 1'b1);
                ce4 += int'(ce[1]   === 1'b1);
            end
            hi5 += int'(vclk[2] === 1'b1);
            if (ce[2] === 1'b1) begin
                ce5++;
                if (last5 >= 0) begin
                    if (k - last5 < gmin) gmin = k - last5;
                    if (k - last5 > gmax) gmax = k - last5;
                end
                last5 = k;
            end
        end
        chk("d4_high_cycles", hi4, 200);
        chk("d4_ce_count",    ce4, 100);
        chk("d5_high_cycles", hi5, 600);
        chk("d5_ce_count",    ce5, 200);
        chk("d5_min_period",  gmin, 5);
        chk("d5_max_period",  gmax, 5);

        // Random resets (and holds) on all instances against the model.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 3; i++) begin
                rst_v[i] = ($urandom_range(0, 49) == 0);
`ifdef VDUCLK_HOLD_EN
                hold_v[i] = ($urandom_range(0, 5) == 0);
`endif
            end
            step();
        end
        rst_v  = 3'b000;
        hold_v = 3'b000;
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
